cic_decim_mc: RTL

Multi-channel, parametrised-order CIC decimator for single-bit sigma-delta modulator streams. It runs entirely in the `clk` domain: a sample strobe replaces the derived divided clock, and the decimation ratio is runtime-programmable as a power of two. Per-channel integrators run at the input rate. One time-multiplexed comb datapath serves all channels and emits gain-normalised words tagged with a channel number. It sits between the modulator front end and downstream digital filtering or readout.

---
 rtl/cic_decim_mc_if.sv | 27 ++
 rtl/cic_decim_mc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc_if.sv
// Stream, control and output signals of the multi-channel CIC decimator.
// The master side feeds modulator bits and control; the slave side is the filter.
interface cic_decim_mc_if #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 16,
  parameter int K_W    = 4,
  parameter int CH_W   = 1
);
  logic [NUM_CH-1:0] in_bits;
  logic              in_valid;
  logic [K_W-1:0]    dec_log2;
  logic              restart;
  logic [OUT_W-1:0]  out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid;
  logic [K_W-1:0]    k_active;

  modport master (
    output in_bits, in_valid, dec_log2, restart,
    input  out_data, out_ch, out_valid, k_active
  );

  modport slave (
    input  in_bits, in_valid, dec_log2, restart,
    output out_data, out_ch, out_valid, k_active
  );
endinterface

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: per-channel integrators at the strobe rate and
// one time-shared comb that sweeps the channels after every completed frame.
module cic_decim_mc #(
  parameter int ORDER   = 3,
  parameter int MAX_DEC = 256,
  parameter int NUM_CH  = 2,
  parameter int DEC_W   = $clog2(MAX_DEC),
  parameter int ACC_W   = ORDER * DEC_W + 1,
  parameter int OUT_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  cic_decim_mc_if.slave bus
);
  localparam int K_W    = $clog2(DEC_W + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int K_MIN  = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int SH_W   = $clog2(ACC_W + 1);
  localparam int WARM_W = $clog2(ORDER + 1);

  typedef enum logic {IDLE, COMB} state_t;

  logic [ACC_W-1:0]  integ      [NUM_CH][ORDER];
  logic [ACC_W-1:0]  integ_next [NUM_CH][ORDER];
  logic [ACC_W-1:0]  snap       [NUM_CH];
  logic [ACC_W-1:0]  dly        [NUM_CH][ORDER];
  logic [ACC_W-1:0]  stage_in   [ORDER+1];
  logic [DEC_W-1:0]  sample_cnt;
  logic [DEC_W-1:0]  cnt_mask;
  logic [WARM_W-1:0] warm_cnt;
  logic              emit;
  logic              frame_done;
  state_t            state;
  logic [CH_W-1:0]   ch_idx;
  logic [K_W-1:0]    k_load;
  logic [SH_W-1:0]   shift_amt;
  logic [ACC_W-1:0]  aligned;
  logic [OUT_W-1:0]  out_word;

  // Each stage accumulates the previous stage's registered value.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      integ_next[c][0] = integ[c][0] + ACC_W'(bus.in_bits[c]);
      for (int i = 1; i < ORDER; i++)
        integ_next[c][i] = integ[c][i] + integ[c][i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < DEC_W; i++)
      cnt_mask[i] = (K_W'(i) < bus.k_active);
  end

  assign frame_done = bus.in_valid && (sample_cnt == cnt_mask);

  always_comb begin
    k_load = bus.dec_log2;
    if (bus.dec_log2 < K_W'(K_MIN))
      k_load = K_W'(K_MIN);
    else if (bus.dec_log2 > K_W'(DEC_W))
      k_load = K_W'(DEC_W);
  end

  // The comb result spans ORDER*k+1 bits; left-align it so full scale is constant across k.
  always_comb begin
    stage_in[0] = snap[ch_idx];
    for (int i = 0; i < ORDER; i++)
      stage_in[i+1] = stage_in[i] - dly[ch_idx][i];
    shift_amt = SH_W'(ACC_W - 1) - SH_W'(ORDER) * SH_W'(bus.k_active);
    aligned   = stage_in[ORDER] << shift_amt;
    out_word  = aligned[ACC_W-1 -: OUT_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        snap[c] <= '0;
        for (int i = 0; i < ORDER; i++) begin
          integ[c][i] <= '0;
          dly[c][i]   <= '0;
        end
      end
      sample_cnt    <= '0;
      warm_cnt      <= '0;
      emit          <= 1'b0;
      state         <= IDLE;
      ch_idx        <= '0;
      bus.k_active  <= K_W'(DEC_W);
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.restart) begin
      for (int c = 0; c < NUM_CH; c++) begin
        snap[c] <= '0;
        for (int i = 0; i < ORDER; i++) begin
          integ[c][i] <= '0;
          dly[c][i]   <= '0;
        end
      end
      sample_cnt    <= '0;
      warm_cnt      <= '0;
      emit          <= 1'b0;
      state         <= IDLE;
      ch_idx        <= '0;
      bus.k_active  <= k_load;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.in_valid) begin
        for (int c = 0; c < NUM_CH; c++)
          for (int i = 0; i < ORDER; i++)
            integ[c][i] <= integ_next[c][i];
        sample_cnt <= frame_done ? '0 : sample_cnt + 1'b1;
      end
      if (frame_done) begin
        for (int c = 0; c < NUM_CH; c++)
          snap[c] <= integ_next[c][ORDER-1];
        emit <= (warm_cnt == WARM_W'(ORDER));
        if (warm_cnt != WARM_W'(ORDER))
          warm_cnt <= warm_cnt + 1'b1;
      end
      // A frame may complete on the last sweep edge when 2^k equals NUM_CH.
      case (state)
        IDLE: begin
          if (frame_done) begin
            state  <= COMB;
            ch_idx <= '0;
          end
        end
        COMB: begin
          for (int i = 0; i < ORDER; i++)
            dly[ch_idx][i] <= stage_in[i];
          bus.out_data  <= out_word;
          bus.out_ch    <= ch_idx;
          bus.out_valid <= emit;
          if (ch_idx == CH_W'(NUM_CH - 1)) begin
            ch_idx <= '0;
            state  <= frame_done ? COMB : IDLE;
          end else begin
            ch_idx <= ch_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
